// File: rtl/mux_nx1_pipe.sv
// N:1 operand select feeding a 2-entry elastic output buffer with valid/ready,
// synchronous flush and sticky/saturating tracking of out-of-range selects.
module mux_nx1_pipe #(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    NUM_IN        = 4,
    parameter int                    SEL_WIDTH     = 2,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_VAL   = '0,
    parameter int                    ERR_CNT_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_flat,
    input  logic [SEL_WIDTH-1:0]         select,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [DATA_WIDTH-1:0]        out,
    output logic                         out_valid,
    input  logic                         out_ready,
    input  logic                         flush,
    output logic                         sel_err,
    output logic [ERR_CNT_WIDTH-1:0]     err_count,
    input  logic                         clr_err
);

    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_bad;
    logic [1:0]            count;
    logic [DATA_WIDTH-1:0] head, tail;
    logic                  push, pop, acc_err;

    always_comb begin
        sel_data = DEFAULT_VAL;
        sel_bad  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (select == SEL_WIDTH'(k)) begin
                sel_data = in_flat[k*DATA_WIDTH +: DATA_WIDTH];
                sel_bad  = 1'b0;
            end
        end
    end

    // in_ready comes straight from the registered count, so no path from out_ready
    assign in_ready  = ~count[1];
    assign out_valid = (count != 2'd0);
    assign out       = out_valid ? head : '0;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign acc_err   = push & sel_bad & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head <= sel_data;
                    else               tail <= sel_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                // push with pop only happens at count 1: new word becomes the head
                2'b11:   head <= sel_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err   <= 1'b0;
            err_count <= '0;
        end else if (clr_err) begin
            sel_err   <= acc_err;
            err_count <= ERR_CNT_WIDTH'(acc_err);
        end else if (acc_err) begin
            sel_err <= 1'b1;
            if (err_count != '1) err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Randomized plus directed bench for mux_nx1_pipe, checked every cycle against a
// queue-based model of the output buffer and error counters.
module tb_mux_nx1_pipe;

    localparam int DW = 16;
    localparam int NI = 3;
    localparam int SW = 2;
    localparam int EW = 2;
    localparam logic [DW-1:0] DEF = 16'hDEAD;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NI*DW-1:0]  in_flat;
    logic [SW-1:0]     select;
    logic              in_valid, in_ready, out_valid, out_ready, flush, sel_err, clr_err;
    logic [DW-1:0]     out;
    logic [EW-1:0]     err_count;

    logic [DW-1:0]     in_w [NI];

    int n_vec = 0;
    int n_bad = 0;

    // model state
    logic [DW-1:0] mq [$];
    int            m_ecnt;
    bit            m_serr;

    mux_nx1_pipe #(.DATA_WIDTH(DW), .NUM_IN(NI), .SEL_WIDTH(SW),
                   .DEFAULT_VAL(DEF), .ERR_CNT_WIDTH(EW)) dut (
        .clk(clk), .rst_n(rst_n), .in_flat(in_flat), .select(select),
        .in_valid(in_valid), .in_ready(in_ready), .out(out), .out_valid(out_valid),
        .out_ready(out_ready), .flush(flush), .sel_err(sel_err),
        .err_count(err_count), .clr_err(clr_err));

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < NI; k++) in_flat[k*DW +: DW] = in_w[k];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // behavioural model: the buffer is a queue of at most two words
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_ecnt = 0;
            m_serr = 0;
        end else begin
            bit p, q, bad, acc;
            logic [DW-1:0] w;
            p   = in_valid && (mq.size() < 2);
            q   = (mq.size() > 0) && out_ready;
            bad = (int'(select) >= NI);
            w   = bad ? DEF : in_w[select];
            if (flush) mq.delete();
            else begin
                if (q) void'(mq.pop_front());
                if (p) mq.push_back(w);
            end
            acc = p && bad && !flush;
            if (clr_err) begin
                m_serr = acc;
                m_ecnt = acc ? 1 : 0;
            end else if (acc) begin
                m_serr = 1;
                if (m_ecnt < (1 << EW) - 1) m_ecnt++;
            end
        end
    end

    always @(negedge clk) begin
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        chk("out",       32'(out),       (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
        chk("in_ready",  32'(in_ready),  32'(mq.size() < 2));
        chk("sel_err",   32'(sel_err),   32'(m_serr));
        chk("err_count", 32'(err_count), 32'(m_ecnt));
    end

    task automatic cyc(input bit v, input int sel, input bit rdy,
                       input bit fl = 0, input bit clr = 0);
        in_valid  = v;
        select    = SW'(sel);
        out_ready = rdy;
        flush     = fl;
        clr_err   = clr;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        in_w[0] = 16'hA0; in_w[1] = 16'hA1; in_w[2] = 16'hA2;
        in_valid = 0; select = 0; out_ready = 0; flush = 0; clr_err = 0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out",       32'(out),       32'd0);
        rst_n = 1'b1;

        // basic routing, one-cycle latency
        cyc(1, 0, 1); chk("route0", 32'(out), 32'hA0);
        cyc(1, 1, 1); chk("route1", 32'(out), 32'hA1);
        cyc(1, 2, 1); chk("route2", 32'(out), 32'hA2);
        cyc(0, 0, 1); chk("drain_empty", 32'(out_valid), 32'd0);

        // backpressure and skid
        in_w[0] = 16'h11; cyc(1, 0, 0);
        in_w[0] = 16'h22; cyc(1, 0, 0);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_head", 32'(out), 32'h11);
        in_w[0] = 16'h33; cyc(1, 0, 0);
        chk("stall_head", 32'(out), 32'h11);
        cyc(1, 0, 1);
        chk("pop_head", 32'(out), 32'h22);
        chk("pop_in_ready", 32'(in_ready), 32'd1);
        cyc(1, 0, 0);
        chk("accept33_head", 32'(out), 32'h22);
        cyc(0, 0, 1); chk("drain33", 32'(out), 32'h33);
        cyc(0, 0, 1); chk("drain_done", 32'(out), 32'd0);

        // simultaneous push/pop at count 1
        in_w[0] = 16'h44; cyc(1, 0, 0);
        in_w[0] = 16'h55; cyc(1, 0, 1);
        chk("pp_out", 32'(out), 32'h55);
        chk("pp_in_ready", 32'(in_ready), 32'd1);
        cyc(0, 0, 1);

        // flush at count 2 with a bad-select push
        cyc(1, 1, 0); cyc(1, 2, 0);
        cyc(1, 3, 0, 1);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_out",   32'(out),       32'd0);
        chk("flush_err",   32'(err_count), 32'd0);

        // out-of-range selects, clear, saturation
        cyc(1, 3, 1); chk("oor_out1", 32'(out), 32'hDEAD);
        cyc(1, 3, 1); chk("oor_out2", 32'(out), 32'hDEAD);
        cyc(1, 3, 1); chk("oor_out3", 32'(out), 32'hDEAD);
        chk("oor_cnt3", 32'(err_count), 32'd3);
        chk("oor_serr", 32'(sel_err), 32'd1);
        cyc(1, 3, 1, 0, 1); chk("clr_cnt1", 32'(err_count), 32'd1);
        repeat (5) cyc(1, 3, 1);
        chk("sat_cnt", 32'(err_count), 32'd3);
        cyc(0, 0, 1, 0, 1); chk("clr_cnt0", 32'(err_count), 32'd0);

        // async reset mid-stream
        cyc(1, 3, 0); cyc(1, 3, 0); in_valid = 0;
        chk("pre_rst_cnt", 32'(err_count), 32'd2);
        chk("pre_rst_full", 32'(in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_out",   32'(out),       32'd0);
        chk("arst_ready", 32'(in_ready),  32'd1);
        chk("arst_serr",  32'(sel_err),   32'd0);
        chk("arst_cnt",   32'(err_count), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        in_w[0] = 16'h77; cyc(1, 0, 0);
        chk("post_rst_push", 32'(out), 32'h77);
        cyc(0, 0, 1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < NI; k++) in_w[k] = DW'($urandom);
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3),
                $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0,
                $urandom_range(0, 29) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
